// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size encodings and FSM states shared by the data-memory responder
package dmem_pkg;
    localparam logic [1:0] MODE_BYTE    = 2'b00;
    localparam logic [1:0] MODE_HALF    = 2'b01;
    localparam logic [1:0] MODE_WORD    = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the addressed lane(s) out of a storage word and sign/zero-extends them
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  mode,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] data
);
    logic [31:0] sh;
    assign sh = word >> {offset, 3'b000};
    always_comb begin
        data = mode == MODE_BYTE ? {{24{~is_unsigned & sh[7]}}, sh[7:0]} :
               mode == MODE_HALF ? {{16{~is_unsigned & sh[15]}}, sh[15:0]} : word;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency byte-addressable data memory with a memory-mapped tag register
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] TAG_ADDR    = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_mode,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] tag
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    logic [31:0] mem [DEPTH_WORDS];
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d, tag_q, tag_d;
    logic        err_q, err_d;
    logic        acc, is_tag, err, wr_mem;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wsh, ld_word, ld_data;
    assign idx     = req_addr[AW+1:2];
    assign is_tag  = req_addr == TAG_ADDR;
    assign err     = req_mode == MODE_ILLEGAL | (req_mode == MODE_HALF & req_addr[0]) |
                     (req_mode == MODE_WORD & |req_addr[1:0]) |
                     (is_tag ? req_mode != MODE_WORD : {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign acc     = req_valid & req_ready;
    assign wr_mem  = acc & req_wr & ~err & ~is_tag & ~rst;
    assign be      = req_mode == MODE_BYTE ? 4'b0001 << req_addr[1:0] :
                     req_mode == MODE_HALF ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wsh     = req_wdata << {req_addr[1:0], 3'b000};
    assign ld_word = is_tag ? tag_q : mem[idx];
    dmem_load_align u_align (
        .word        (ld_word),
        .mode        (req_mode),
        .offset      (req_addr[1:0]),
        .is_unsigned (req_unsigned),
        .data        (ld_data)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tag_d   = tag_q;
        if (acc) begin
            state_d = LATENCY == 1 ? RESP : BUSY;
            cnt_d   = LATENCY == 1 ? 4'd0 : 4'(LATENCY - 2);
            rdata_d = (err | req_wr) ? 32'd0 : ld_data;
            err_d   = err;
            tag_d   = (req_wr & is_tag & ~err) ? req_wdata : tag_q;
        end
        if (state_q == BUSY) begin
            state_d = cnt_q == 4'd0 ? RESP : BUSY;
            cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        end
        if (state_q == RESP && rsp_ready) state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tag_q   <= tag_d;
        end
    end
    // storage survives reset; only a committed store changes it
    always_ff @(posedge clk) begin
        if (wr_mem)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][i*8 +: 8] <= wsh[i*8 +: 8];
    end
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign tag       = tag_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random transactions checked against a byte-level memory model
module tb_dmem_responder;
    localparam int          LAT = 2;
    localparam logic [31:0] TAG = 32'hFFFF_FFF0;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_wr, req_unsigned, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  req_mode;
    logic [31:0] req_addr, req_wdata, rsp_rdata, tag;
    int checks = 0;
    int failures = 0;
    logic [31:0] mref [256];
    logic [31:0] tag_ref;
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT), .TAG_ADDR(TAG)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_mode(req_mode), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .tag(tag)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask
    function automatic void model(input logic wr, input logic [1:0] mode, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] erd, output logic eer);
        longint unsigned m, w, v;
        int sh, nb, wi;
        nb  = mode == 2'd0 ? 1 : mode == 2'd1 ? 2 : 4;
        wi  = int'(addr >> 2);
        eer = mode == 2'd3 || (mode == 2'd1 && addr % 2 != 0) || (mode == 2'd2 && addr % 4 != 0) ||
              (addr == TAG ? mode != 2'd2 : addr / 4 >= 256);
        erd = '0;
        if (eer) return;
        if (addr == TAG) begin
            if (wr) tag_ref = wdata;
            else erd = tag_ref;
            return;
        end
        m  = (64'd1 << (8 * nb)) - 1;
        sh = 8 * int'(addr % 4);
        w  = 64'(mref[wi]);
        if (wr) mref[wi] = 32'((w & ~(m << sh)) | ((64'(wdata) & m) << sh));
        else begin
            v = (w >> sh) & m;
            if (!uns && v[8*nb-1]) v = v | ~m;
            erd = v[31:0];
        end
    endfunction
    task automatic txn(input logic wr, input logic [1:0] mode, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       input string name);
        logic [31:0] erd, rd;
        logic eer, er;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_mode = mode; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk({name, "_accept"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        model(wr, mode, uns, addr, wdata, erd, eer);
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_mode = 2'($urandom);
        chk({name, "_tag"}, tag, tag_ref);
        n = 1;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        chk({name, "_latency"}, 32'(n), 32'(LAT));
        rd = rsp_rdata;
        er = rsp_err;
        chk({name, "_rdata"}, rd, erd);
        chk({name, "_err"}, 32'(er), 32'(eer));
        repeat (hold) begin
            chk({name, "_hold_ctl"}, 32'({rsp_valid, req_ready, rsp_err}), 32'({2'b10, er}));
            chk({name, "_hold_data"}, rsp_rdata, rd);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, "_done"}, 32'({rsp_valid, req_ready}), 32'b01);
    endtask
    initial begin
        logic [31:0] a, erd;
        logic eer;
        int r;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_wr = 1'b0; req_mode = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; tag_ref = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", 32'({req_ready, rsp_valid, rsp_err}), 32'b100);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_tag", tag, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) txn(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0, "init");
        txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, "st_w10");
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "ld_w10");
        txn(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, "ld_b13s");
        txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, "ld_b13u");
        txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, "ld_h12s");
        txn(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 0, "st_h11_mis");
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "ld_w10_again");
        txn(1'b1, 2'd2, 1'b0, TAG, 32'h0000_00A5, 0, "st_tag");
        txn(1'b0, 2'd2, 1'b0, TAG, 32'h0, 0, "ld_tag");
        txn(1'b1, 2'd0, 1'b0, TAG, 32'hFF, 0, "st_tag_byte");
        txn(1'b1, 2'd2, 1'b0, 32'h400, 32'h5555_5555, 0, "st_oor");
        txn(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, "ld_illegal");
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, "ld_hold");
        // reset wins over a request presented in the same cycle
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_mode = 2'd2;
        req_addr = 32'h24; req_wdata = ~mref[9];
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; tag_ref = '0;
        chk("rstpri_ctl", 32'({req_ready, rsp_valid, rsp_err}), 32'b100);
        chk("rstpri_rdata", rsp_rdata, 32'd0);
        chk("rstpri_tag", tag, 32'd0);
        txn(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 0, "ld_w24");
        // reset during BUSY drops the response but keeps the committed store
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_mode = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h1111_1111;
        r = 0;
        while (!req_ready && r < 50) begin @(negedge clk); r++; end
        @(posedge clk);
        model(1'b1, 2'd2, 1'b0, 32'h20, 32'h1111_1111, erd, eer);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; tag_ref = '0;
        chk("rstbusy_ready", 32'(req_ready), 32'd1);
        repeat (LAT + 2) begin
            chk("rstbusy_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, "ld_w20");
        repeat (150) begin
            r = $urandom_range(0, 99);
            a = r < 70 ? 32'($urandom_range(0, 63)) :
                r < 85 ? TAG + 32'($urandom_range(0, 3)) :
                r < 95 ? 32'h400 + 32'($urandom_range(0, 4095)) : $urandom;
            txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 2), "rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit storage words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-003 SHALL have parameter TAG_ADDR, default 32'hFFFF_FFF0, meaning the byte address of the memory-mapped tag register.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_wr  input  1  1 = store, 0 = load.
REQ-009 req_mode  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_addr  input  32  byte address.
REQ-012 req_wdata  input  32  store data, right-aligned.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  initiator takes the response.
REQ-015 rsp_rdata  output  32  load result, right-aligned and extended; 0 for stores and errors.
REQ-016 rsp_err  output  1  request was misaligned, out of range or illegal mode.
REQ-017 tag  output  32  current tag register value.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, RESP; req_ready=1 only in IDLE, rsp_valid=1 only in RESP.
REQ-019 Request accepted on edge where req_valid & req_ready; all request fields sampled at that edge only.
REQ-020 Acceptance: IDLE->RESP if LATENCY=1, else IDLE->BUSY with counter loaded to LATENCY-2.
REQ-021 BUSY: counter decrements each cycle; BUSY->RESP on the edge where counter is 0; rsp_valid first high exactly LATENCY cycles after the acceptance edge.
REQ-022 RESP: rsp_valid, rsp_rdata and rsp_err held stable until rsp_valid & rsp_ready; then RESP->IDLE (no back-to-back acceptance in that cycle).
REQ-023 Error conditions: req_mode=11; half with addr[0]=1; word with addr[1:0]!=00; word index addr[31:2] >= DEPTH_WORDS and addr != TAG_ADDR; any non-word access to TAG_ADDR.
REQ-024 Erroneous requests SHALL still complete the full handshake with rsp_err=1, rsp_rdata=0, and SHALL NOT modify storage or tag.
REQ-025 Stores SHALL commit at the acceptance edge, updating only addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2 and +1; word: all).
REQ-026 Loads SHALL capture storage at the acceptance edge and extract lane(s) per addr[1:0], extending per req_unsigned to 32 bits.
REQ-027 Word store to TAG_ADDR SHALL update tag at acceptance edge; word load from TAG_ADDR returns tag.
REQ-028 req_valid while not in IDLE SHALL be ignored; initiator holds it until accepted.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, tag=0, req_ready=1 the next cycle.
REQ-030 Reset mid-operation SHALL abandon the transaction with no response; a store already committed remains; storage array is not cleared by reset.
REQ-031 rst SHALL take priority over a simultaneous request acceptance (request not accepted, no write).

Structure
REQ-032 Shared package dmem_pkg SHALL hold mode encodings MODE_BYTE, MODE_HALF, MODE_WORD, MODE_ILLEGAL and the FSM state enum.
REQ-033 Combinational load lane-extract/extend logic SHALL be one sub-module named dmem_load_align.

Verification
REQ-034 Word store 32'hDEAD_BEEF @0x10, then word load @0x10, LATENCY=2 -> rsp_valid 2 cycles after each acceptance, rsp_rdata=32'hDEAD_BEEF, rsp_err=0.
REQ-035 After REQ-034, byte load @0x13 signed -> 32'hFFFF_FFDE; unsigned -> 32'h0000_00DE; half load @0x12 signed -> 32'hFFFF_DEAD.
REQ-036 Half store 16'h1234 @0x11 -> rsp_err=1, rsp_rdata=0; subsequent word load @0x10 still 32'hDEAD_BEEF.
REQ-037 Word store 32'h0000_00A5 @TAG_ADDR -> tag=32'h0000_00A5 after acceptance edge; byte store to TAG_ADDR -> rsp_err=1, tag unchanged.
REQ-038 Load with rsp_ready low for 5 cycles in RESP -> rsp_valid and data stable all 5 cycles; req_ready low until cycle after handshake.
REQ-039 rst pulse during BUSY of a word store 32'h1111_1111 @0x20 -> no rsp_valid, req_ready=1 next cycle, later load @0x20 returns 32'h1111_1111.
